compare_initiator_scoreboard: RTL and testbench

- Initiator and scoreboard for the output-layer argmax/compare stage.
- Accepts one 4-bit target label per inference and encodes it to one-hot. Pulses start_state3, holds target_label_onehot stable, and waits for end_state3.
- Captures output_index and matched, then accumulates running accuracy statistics for readout by the top-level controller.

---
 rtl/compare_initiator_scoreboard.sv | 173 +++++++++++++++++
 tb/tb_compare_initiator_scoreboard.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compare_initiator_scoreboard.sv
// compare_initiator_scoreboard: label initiator and accuracy scoreboard for the argmax stage.
// Optional per-class hit counters enabled by defining CONFUSION_STATS_EN.
module compare_initiator_scoreboard #(
  parameter int NOUT    = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             label_valid,
  input  logic [3:0]       label_in,
  output logic             label_ready,
  input  logic             clear,
  output logic             start_state3,
  output logic [NOUT-1:0]  target_label_onehot,
  input  logic             end_state3,
  input  logic             matched,
  input  logic [3:0]       output_index,
  output logic             result_valid,
  output logic [3:0]       result_index,
  output logic             result_correct,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] correct_count,
  input  logic [3:0]       class_sel,
  output logic [CNT_W-1:0] class_hit_count,
  output logic             timeout_err,
  output logic             label_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_START  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]       r_state;
  logic [TW-1:0]    r_timer;
  logic [NOUT-1:0]  r_onehot;
  logic [3:0]       r_res_idx;
  logic             r_res_ok;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_correct;
  logic             r_tmo_err;
  logic             r_lbl_err;

  logic w_idle;
  logic w_lbl_ok;
  logic w_accept;
  logic w_bad;
  logic w_done;
  logic w_tmo;
  logic w_report;

  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_lbl_ok = ({28'd0, label_in} < 32'(NOUT));
  assign w_accept = w_idle & label_valid & w_lbl_ok;
  assign w_bad    = w_idle & label_valid & ~w_lbl_ok;
  assign w_done   = (r_state == S_WAIT) & end_state3;
  assign w_tmo    = (r_state == S_WAIT) & ~end_state3
                  & (r_timer == TW'(TIMEOUT - 1));
  assign w_report = (r_state == S_REPORT);

  // Handshake FSM and WAIT_END watchdog timer
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) r_state <= S_START;
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_done)     r_state <= S_REPORT;
          else if (w_tmo) r_state <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Latched one-hot target and captured compare result
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_onehot  <= '0;
      r_res_idx <= '0;
      r_res_ok  <= 1'b0;
    end else begin
      if (w_accept) r_onehot <= NOUT'(1) << label_in;
      if (w_done) begin
        r_res_idx <= output_index;
        r_res_ok  <= matched;
      end
    end
  end

  // Saturating accuracy counters; clear overrides a same-cycle update
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (clear) begin
      r_total   <= '0;
      r_correct <= '0;
    end else if (w_report) begin
      r_total <= f_inc(r_total);
      if (r_res_ok) r_correct <= f_inc(r_correct);
    end
  end

  // Sticky errors; a new error outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_tmo_err <= 1'b0;
      r_lbl_err <= 1'b0;
    end else begin
      if (w_tmo)      r_tmo_err <= 1'b1;
      else if (clear) r_tmo_err <= 1'b0;
      if (w_bad)      r_lbl_err <= 1'b1;
      else if (clear) r_lbl_err <= 1'b0;
    end
  end

`ifdef CONFUSION_STATS_EN
  logic [CNT_W-1:0] r_cls [NOUT];
  logic [CNT_W-1:0] w_hit;

  // Per-class hit counters indexed by the latched one-hot label
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < NOUT; i++) r_cls[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NOUT; i++) r_cls[i] <= '0;
    end else if (w_report && r_res_ok) begin
      for (int i = 0; i < NOUT; i++)
        if (r_onehot[i]) r_cls[i] <= f_inc(r_cls[i]);
    end
  end

  // Readout mux; out-of-range selectors read zero
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NOUT; i++)
      if (class_sel == 4'(i)) w_hit = r_cls[i];
  end

  assign class_hit_count = w_hit;
`else
  logic w_unused_class_sel;

  assign w_unused_class_sel = ^class_sel;
  assign class_hit_count    = '0;
`endif

  assign label_ready         = w_idle;
  assign start_state3        = (r_state == S_START);
  assign target_label_onehot = r_onehot;
  assign result_valid        = w_report;
  assign result_index        = r_res_idx;
  assign result_correct      = r_res_ok;
  assign total_count         = r_total;
  assign correct_count       = r_correct;
  assign timeout_err         = r_tmo_err;
  assign label_err           = r_lbl_err;

endmodule

// File: tb/tb_compare_initiator_scoreboard.sv
// tb_compare_initiator_scoreboard: random transactions vs a counting model.
// Built with or without CONFUSION_STATS_EN; expectations follow the macro.
module tb_compare_initiator_scoreboard;

  localparam int NOUT = 10;
  localparam int CW   = 4;
  localparam int TMO  = 15;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk;
  logic            reset_b;
  logic            label_valid;
  logic [3:0]      label_in;
  logic            label_ready;
  logic            clear;
  logic            start_state3;
  logic [NOUT-1:0] target_label_onehot;
  logic            end_state3;
  logic            matched;
  logic [3:0]      output_index;
  logic            result_valid;
  logic [3:0]      result_index;
  logic            result_correct;
  logic [CW-1:0]   total_count;
  logic [CW-1:0]   correct_count;
  logic [3:0]      class_sel;
  logic [CW-1:0]   class_hit_count;
  logic            timeout_err;
  logic            label_err;

  compare_initiator_scoreboard #(
    .NOUT(NOUT), .CNT_W(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .label_valid(label_valid),
    .label_in(label_in),
    .label_ready(label_ready),
    .clear(clear),
    .start_state3(start_state3),
    .target_label_onehot(target_label_onehot),
    .end_state3(end_state3),
    .matched(matched),
    .output_index(output_index),
    .result_valid(result_valid),
    .result_index(result_index),
    .result_correct(result_correct),
    .total_count(total_count),
    .correct_count(correct_count),
    .class_sel(class_sel),
    .class_hit_count(class_hit_count),
    .timeout_err(timeout_err),
    .label_err(label_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // model state
  int m_total;
  int m_correct;
  int m_cls [NOUT];
  int m_tmo;
  int m_lbl;
  int m_oh;
  int m_ridx;
  int m_rok;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  task automatic m_reset();
    m_total = 0; m_correct = 0; m_tmo = 0; m_lbl = 0;
    m_oh = 0; m_ridx = 0; m_rok = 0;
    for (int i = 0; i < NOUT; i++) m_cls[i] = 0;
  endtask

  task automatic m_clear();
    m_total = 0; m_correct = 0; m_tmo = 0; m_lbl = 0;
    for (int i = 0; i < NOUT; i++) m_cls[i] = 0;
  endtask

  task automatic check_stats(input string tag);
    int e;
    chk({tag, "_total"}, 32'(total_count), 32'(m_total));
    chk({tag, "_correct"}, 32'(correct_count), 32'(m_correct));
    chk({tag, "_tmo_err"}, 32'(timeout_err), 32'(m_tmo));
    chk({tag, "_lbl_err"}, 32'(label_err), 32'(m_lbl));
    chk({tag, "_ridx"}, 32'(result_index), 32'(m_ridx));
    chk({tag, "_rok"}, 32'(result_correct), 32'(m_rok));
    for (int c = 0; c < 16; c++) begin
      class_sel = 4'(c);
      #1;
      e = 0;
`ifdef CONFUSION_STATS_EN
      if (c < NOUT) e = m_cls[c];
`endif
      chk({tag, "_class_hit"}, 32'(class_hit_count), 32'(e));
    end
  endtask

  task automatic do_sample(input int lbl, input int dly, input int idx,
                           input int m, input bit clr);
    chk("ready_idle", 32'(label_ready), 32'd1);
    label_valid = 1'b1;
    label_in    = 4'(lbl);
    tick();
    m_oh = 1 << lbl;
    chk("start_hi", 32'(start_state3), 32'd1);
    chk("ready_busy", 32'(label_ready), 32'd0);
    chk("onehot", 32'(target_label_onehot), 32'(m_oh));
    label_in = 4'($urandom_range(0, 9));
    tick();
    chk("start_lo", 32'(start_state3), 32'd0);
    repeat (dly) tick();
    label_valid  = 1'b0;
    end_state3   = 1'b1;
    matched      = m[0];
    output_index = 4'(idx);
    tick();
    end_state3 = 1'b0;
    m_ridx = idx;
    m_rok  = m;
    chk("rv_hi", 32'(result_valid), 32'd1);
    chk("res_idx", 32'(result_index), 32'(idx));
    chk("res_ok", 32'(result_correct), 32'(m));
    chk("onehot_held", 32'(target_label_onehot), 32'(m_oh));
    clear = clr;
    tick();
    clear = 1'b0;
    if (clr) m_clear();
    else begin
      m_total = sat(m_total);
      if (m != 0) begin
        m_correct  = sat(m_correct);
        m_cls[lbl] = sat(m_cls[lbl]);
      end
    end
    chk("rv_lo", 32'(result_valid), 32'd0);
    chk("ready_back", 32'(label_ready), 32'd1);
    check_stats("sample");
  endtask

  task automatic do_timeout(input int lbl);
    label_valid = 1'b1;
    label_in    = 4'(lbl);
    tick();
    label_valid = 1'b0;
    m_oh = 1 << lbl;
    chk("to_start", 32'(start_state3), 32'd1);
    tick();
    repeat (TMO - 1) tick();
    chk("to_wait", 32'(label_ready), 32'd0);
    chk("to_err_pre", 32'(timeout_err), 32'(m_tmo));
    tick();
    m_tmo = 1;
    chk("to_idle", 32'(label_ready), 32'd1);
    chk("to_err", 32'(timeout_err), 32'd1);
    end_state3   = 1'b1;
    matched      = 1'b1;
    output_index = 4'd5;
    tick();
    end_state3 = 1'b0;
    chk("late_rv", 32'(result_valid), 32'd0);
    chk("late_start", 32'(start_state3), 32'd0);
    chk("late_ready", 32'(label_ready), 32'd1);
    chk("late_onehot", 32'(target_label_onehot), 32'(m_oh));
    check_stats("timeout");
  endtask

  task automatic do_bad(input int lbl, input bit clr);
    chk("bad_ready_pre", 32'(label_ready), 32'd1);
    label_valid = 1'b1;
    label_in    = 4'(lbl);
    clear       = clr;
    tick();
    label_valid = 1'b0;
    clear       = 1'b0;
    if (clr) m_clear();
    m_lbl = 1;
    chk("bad_ready", 32'(label_ready), 32'd1);
    chk("bad_start", 32'(start_state3), 32'd0);
    chk("bad_onehot", 32'(target_label_onehot), 32'(m_oh));
    tick();
    chk("bad_start2", 32'(start_state3), 32'd0);
    check_stats("bad");
  endtask

  task automatic do_idle_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_clear();
    check_stats("clear");
  endtask

  task automatic rand_sample(input bit clr);
    int lbl;
    int idx;
    lbl = $urandom_range(0, 9);
    idx = ($urandom_range(0, 1) == 1) ? lbl : $urandom_range(0, 9);
    do_sample(lbl, $urandom_range(0, TMO - 1), idx,
              (idx == lbl) ? 1 : 0, clr);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_b      = 1'b1;
    label_valid  = 1'b0;
    label_in     = '0;
    clear        = 1'b0;
    end_state3   = 1'b0;
    matched      = 1'b0;
    output_index = '0;
    class_sel    = '0;
    m_reset();
    #2 reset_b = 1'b0;
    #1;
    chk("rst_ready", 32'(label_ready), 32'd1);
    chk("rst_start", 32'(start_state3), 32'd0);
    chk("rst_onehot", 32'(target_label_onehot), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    check_stats("rst");
    tick();
    tick();
    reset_b = 1'b1;
    tick();

    do_sample(3, 8, 3, 1, 1'b0);
    do_sample(7, 4, 2, 0, 1'b0);
    do_bad(12, 1'b0);
    do_timeout(5);
    do_sample(TMO - 1 > 9 ? 9 : 1, TMO - 1, 9, 1, 1'b0);
    do_sample(4, 2, 4, 1, 1'b1);
    do_bad(15, 1'b1);
    do_idle_clear();

    for (int k = 0; k < MAXC + 3; k++) do_sample(0, 1, 0, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        6:       do_bad($urandom_range(10, 15), 1'($urandom_range(0, 1)));
        7:       do_timeout($urandom_range(0, 9));
        8:       rand_sample(1'b1);
        9:       do_idle_clear();
        default: rand_sample(1'b0);
      endcase
    end

    label_valid = 1'b1;
    label_in    = 4'd6;
    tick();
    label_valid = 1'b0;
    chk("mid_start", 32'(start_state3), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    m_reset();
    chk("mid_rst_start", 32'(start_state3), 32'd0);
    chk("mid_rst_ready", 32'(label_ready), 32'd1);
    chk("mid_rst_onehot", 32'(target_label_onehot), 32'd0);
    check_stats("mid_rst");
    tick();
    reset_b = 1'b1;
    tick();
    do_sample(8, 3, 8, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
